// File: rtl/tc_deser.sv
// tc_deser: collects an LSB-first serial bit stream into W-bit words and
// presents each completed word on a valid/ready output register. Framing
// comes from s_first, which marks bit 0 of every word. Framing violations
// and dropped words are reported as single-cycle registered pulses.
//
// Output handshake: a word is transferred on every rising edge where
// m_valid && m_ready. m_data is held stable while m_valid=1 and m_ready=0.
// A word completing on the same edge as a transfer replaces the taken word
// with no bubble. A word completing while the held word is not taken is
// dropped.
module tc_deser #(
  parameter int W = 8
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic         s_bit,
  input  logic         s_valid,
  input  logic         s_first,
  output logic [W-1:0] m_data,
  output logic         m_sign,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         frame_err,
  output logic         ovr_err,
  output logic         dbg_state
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [W-1:0]   sh;

  logic           accept;
  logic           bad_frame;
  logic           done;
  logic           out_free;
  logic [CW-1:0]  idx;
  logic [W-1:0]   cur_word;

  // Decode the current input bit: where it lands, whether it completes a
  // word, and whether it breaks framing.
  always_comb begin
    accept    = s_valid && (s_first || (state == SHIFT));
    bad_frame = s_valid && (((state == IDLE) && !s_first) ||
                            ((state == SHIFT) && s_first));
    idx       = s_first ? '0 : count;
    // A restart clears any stale bits left by an abandoned partial word.
    cur_word  = s_first ? '0 : sh;
    for (int i = 0; i < W; i++) begin
      if (CW'(i) == idx) cur_word[i] = s_bit;
    end
    done      = accept && (idx == CW'(W - 1));
    out_free  = !m_valid || m_ready;
  end

  // Framing FSM, shift register, output register and error pulses.
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state     <= IDLE;
      count     <= '0;
      sh        <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      ovr_err   <= done && !out_free;

      if (accept) begin
        sh <= cur_word;
        if (done) begin
          state <= IDLE;
          count <= '0;
        end else begin
          state <= SHIFT;
          count <= idx + CW'(1);
        end
      end

      if (done && out_free) begin
        m_data  <= cur_word;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign m_sign    = m_data[W-1];
  assign dbg_state = state;

endmodule

// File: tb/tb_tc_deser.sv
// tb_tc_deser: directed bench for tc_deser (W=8). A vector table covers
// plain word collection with and without gaps; hand-written sequences cover
// overrun, same-edge replacement, framing errors and asynchronous reset.
module tb_tc_deser;

  logic       t_clk;
  logic       r;
  logic       s_bit;
  logic       s_valid;
  logic       s_first;
  logic [7:0] m_data;
  logic       m_sign;
  logic       m_valid;
  logic       m_ready;
  logic       frame_err;
  logic       ovr_err;
  logic       dbg_state;

  int n_checks = 0;
  int errors   = 0;

  tc_deser #(.W(8)) dut (
    .t_clk     (t_clk),
    .r         (r),
    .s_bit     (s_bit),
    .s_valid   (s_valid),
    .s_first   (s_first),
    .m_data    (m_data),
    .m_sign    (m_sign),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .ovr_err   (ovr_err),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  typedef struct {
    logic [7:0] word;
    bit         holes;
    logic [7:0] exp_data;
    logic       exp_sign;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of serial input, then sample 1 time unit after the edge.
  task automatic tick_bit(input logic v, input logic b, input logic f);
    s_valid = v;
    s_bit   = b;
    s_first = f;
    @(posedge t_clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  // Send a full 8-bit word LSB first; optionally insert a hole before each
  // bit after the first and check that no output appears before the last bit.
  task automatic send_word(input logic [7:0] w, input bit holes, input bit chk_low,
                           input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      if (holes && i > 0) begin
        tick_bit(1'b0, 1'b0, 1'b0);
        if (chk_low) check("valid_low_hole", {31'd0, m_valid}, 32'd0);
      end
      if (i == 7) m_ready = rdy_last;
      tick_bit(1'b1, w[i], (i == 0));
      if (chk_low && i < 7) check("valid_low_bit", {31'd0, m_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [7:0] w;

    vecs[0] = '{word: 8'hF6, holes: 1'b0, exp_data: 8'hF6, exp_sign: 1'b1};
    vecs[1] = '{word: 8'hF6, holes: 1'b1, exp_data: 8'hF6, exp_sign: 1'b1};
    vecs[2] = '{word: 8'h00, holes: 1'b0, exp_data: 8'h00, exp_sign: 1'b0};
    vecs[3] = '{word: 8'hFF, holes: 1'b1, exp_data: 8'hFF, exp_sign: 1'b1};
    vecs[4] = '{word: 8'h01, holes: 1'b0, exp_data: 8'h01, exp_sign: 1'b0};
    vecs[5] = '{word: 8'h80, holes: 1'b1, exp_data: 8'h80, exp_sign: 1'b1};

    r       = 1'b0;
    s_bit   = 1'b0;
    s_valid = 1'b0;
    s_first = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge t_clk);
    #1;
    check("rst_data",  {24'd0, m_data}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_oerr",  {31'd0, ovr_err}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    r = 1'b1;
    tick_bit(1'b0, 1'b0, 1'b0);

    // Table: plain words, with and without holes, m_ready held high
    for (int k = 0; k < 6; k++) begin
      m_ready = 1'b1;
      send_word(vecs[k].word, vecs[k].holes, 1'b1, 1'b1);
      check("vec_data",  {24'd0, m_data}, {24'd0, vecs[k].exp_data});
      check("vec_sign",  {31'd0, m_sign}, {31'd0, vecs[k].exp_sign});
      check("vec_valid", {31'd0, m_valid}, 32'd1);
      check("vec_ferr",  {31'd0, frame_err}, 32'd0);
      check("vec_oerr",  {31'd0, ovr_err}, 32'd0);
      check("vec_state", {31'd0, dbg_state}, 32'd0);
      tick_bit(1'b0, 1'b0, 1'b0);
      check("vec_valid_drop", {31'd0, m_valid}, 32'd0);
    end

    // Overrun: 0A held, 05 completes and is dropped
    m_ready = 1'b0;
    send_word(8'h0A, 1'b0, 1'b0, 1'b0);
    check("ovr_hold_valid", {31'd0, m_valid}, 32'd1);
    check("ovr_hold_data",  {24'd0, m_data}, 32'h0A);
    send_word(8'h05, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", {31'd0, ovr_err}, 32'd1);
    check("ovr_data",  {24'd0, m_data}, 32'h0A);
    check("ovr_valid", {31'd0, m_valid}, 32'd1);
    tick_bit(1'b0, 1'b0, 1'b0);
    check("ovr_pulse_end", {31'd0, ovr_err}, 32'd0);
    check("ovr_data_stable", {24'd0, m_data}, 32'h0A);
    m_ready = 1'b1;
    tick_bit(1'b0, 1'b0, 1'b0);
    check("ovr_take_valid", {31'd0, m_valid}, 32'd0);
    check("ovr_take_data",  {24'd0, m_data}, 32'h0A);

    // Same-edge replacement: 0A held, taken on 33's completion edge
    m_ready = 1'b0;
    send_word(8'h0A, 1'b0, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0, 1'b1);
    check("repl_data",  {24'd0, m_data}, 32'h33);
    check("repl_valid", {31'd0, m_valid}, 32'd1);
    check("repl_oerr",  {31'd0, ovr_err}, 32'd0);
    tick_bit(1'b0, 1'b0, 1'b0);
    check("repl_drop", {31'd0, m_valid}, 32'd0);

    // Framing: restart after 3 bits, then a stray bit in IDLE
    m_ready = 1'b1;
    tick_bit(1'b1, 1'b1, 1'b1);
    tick_bit(1'b1, 1'b0, 1'b0);
    tick_bit(1'b1, 1'b1, 1'b0);
    check("fr_partial_state", {31'd0, dbg_state}, 32'd1);
    check("fr_partial_ferr",  {31'd0, frame_err}, 32'd0);
    w = 8'h81;
    tick_bit(1'b1, w[0], 1'b1);
    check("fr_restart_ferr",  {31'd0, frame_err}, 32'd1);
    check("fr_restart_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 1; i < 8; i++) tick_bit(1'b1, w[i], 1'b0);
    check("fr_data",  {24'd0, m_data}, 32'h81);
    check("fr_valid", {31'd0, m_valid}, 32'd1);
    check("fr_ferr_once", {31'd0, frame_err}, 32'd0);
    tick_bit(1'b0, 1'b0, 1'b0);
    tick_bit(1'b1, 1'b1, 1'b0);
    check("stray_ferr",  {31'd0, frame_err}, 32'd1);
    check("stray_valid", {31'd0, m_valid}, 32'd0);
    check("stray_state", {31'd0, dbg_state}, 32'd0);
    tick_bit(1'b0, 1'b0, 1'b0);
    check("stray_ferr_end", {31'd0, frame_err}, 32'd0);

    // Asynchronous reset mid-word with a pending output
    m_ready = 1'b0;
    send_word(8'h0A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick_bit(1'b1, 1'b1, (i == 0));
    #2;
    r = 1'b0;
    #1;
    check("arst_data",  {24'd0, m_data}, 32'd0);
    check("arst_valid", {31'd0, m_valid}, 32'd0);
    check("arst_sign",  {31'd0, m_sign}, 32'd0);
    check("arst_state", {31'd0, dbg_state}, 32'd0);
    @(negedge t_clk);
    r = 1'b1;
    @(posedge t_clk);
    #1;
    m_ready = 1'b1;
    send_word(8'h7F, 1'b0, 1'b1, 1'b1);
    check("post_rst_data",  {24'd0, m_data}, 32'h7F);
    check("post_rst_sign",  {31'd0, m_sign}, 32'd0);
    check("post_rst_valid", {31'd0, m_valid}, 32'd1);
    check("post_rst_ferr",  {31'd0, frame_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
